// File: rtl/hit_event_gen_if.sv
// hit_event_gen_if: sprite positions and tick in, event/lives/score status out.
interface hit_event_gen_if;
    logic        tick;
    logic [9:0]  d_x, d_y, r_x, r_y, m_x, m_y;
    logic        d_valid, r_valid, m_valid;
    logic [1:0]  Event;
    logic [2:0]  lives;
    logic        game_over;
    logic [15:0] hit_cnt;

    modport master (
        output tick, d_x, d_y, r_x, r_y, m_x, m_y, d_valid, r_valid, m_valid,
        input  Event, lives, game_over, hit_cnt
    );
    modport slave (
        input  tick, d_x, d_y, r_x, r_y, m_x, m_y, d_valid, r_valid, m_valid,
        output Event, lives, game_over, hit_cnt
    );
endinterface

// File: rtl/hit_event_gen.sv
// hit_event_gen: sprite overlap tests feeding per-channel hold/cooldown FSMs and a lives counter.
// Define HIT_EVENT_STATS_EN to build the saturating missile hit counter on hit_cnt.
module hit_event_gen #(
    parameter int D_W        = 32,
    parameter int D_H        = 32,
    parameter int R_W        = 32,
    parameter int R_H        = 32,
    parameter int M_W        = 8,
    parameter int M_H        = 16,
    parameter int HOLD_TICKS = 2,
    parameter int COOL_TICKS = 8,
    parameter int LIVES      = 3
) (
    input  logic           clk,
    input  logic           rst,
    hit_event_gen_if.slave bus
);
    localparam int CW = $clog2((HOLD_TICKS > COOL_TICKS ? HOLD_TICKS : COOL_TICKS) + 1);

    typedef enum logic [1:0] {ARMED, HOLD, COOL} state_t;

    // 11-bit sums so boxes near the right/bottom edge do not wrap
    function automatic logic overlap(input logic [9:0] ax, ay, bx, by, input logic [10:0] aw, ah, bw, bh);
        return ({1'b0, ax} < {1'b0, bx} + bw) && ({1'b0, bx} < {1'b0, ax} + aw) &&
               ({1'b0, ay} < {1'b0, by} + bh) && ({1'b0, by} < {1'b0, ay} + ah);
    endfunction

    logic [1:0]    ovl_raw, ovl_q, ovl;
    state_t        st [2];
    state_t        st_nx [2];
    logic [CW-1:0] cnt [2];
    logic [CW-1:0] cnt_nx [2];
    logic [2:0]    lives;
    logic          game_over, fire_dr;

    assign ovl_raw[0] = bus.d_valid && bus.r_valid &&
                        overlap(bus.d_x, bus.d_y, bus.r_x, bus.r_y, 11'(D_W), 11'(D_H), 11'(R_W), 11'(R_H));
    assign ovl_raw[1] = bus.m_valid && bus.d_valid &&
                        overlap(bus.m_x, bus.m_y, bus.d_x, bus.d_y, 11'(M_W), 11'(M_H), 11'(D_W), 11'(D_H));
    assign ovl        = bus.tick ? ovl_raw : ovl_q;
    assign game_over  = lives == 3'd0 && st[0] != HOLD && st[1] != HOLD;
    assign fire_dr    = st[0] == ARMED && st_nx[0] == HOLD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                st[c]  <= ARMED;
                cnt[c] <= '0;
            end
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_nx[c]  = st[c];
            cnt_nx[c] = cnt[c];
            if (game_over) begin
                st_nx[c]  = ARMED;
                cnt_nx[c] = '0;
            end else if (bus.tick) begin
                case (st[c])
                    ARMED: if (ovl[c] && lives != 3'd0) begin
                        st_nx[c]  = HOLD;
                        cnt_nx[c] = CW'(HOLD_TICKS);
                    end
                    HOLD: begin
                        cnt_nx[c] = cnt[c] - CW'(1);
                        if (cnt[c] == CW'(1)) begin
                            st_nx[c]  = COOL;
                            cnt_nx[c] = CW'(COOL_TICKS);
                        end
                    end
                    // stuck-together sprites keep the channel in COOL until they separate
                    default: if (cnt[c] != '0) cnt_nx[c] = cnt[c] - CW'(1);
                             else if (!ovl[c]) st_nx[c] = ARMED;
                endcase
            end
        end
    end

    always_comb begin
        bus.Event     = {st[1] == HOLD, st[0] == HOLD};
        bus.lives     = lives;
        bus.game_over = game_over;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovl_q <= '0;
            lives <= 3'(LIVES);
        end else begin
            ovl_q <= ovl;
            if (fire_dr && lives != 3'd0) lives <= lives - 3'd1;
        end
    end

`ifdef HIT_EVENT_STATS_EN
    logic        fire_md;
    logic [15:0] hit_cnt;

    assign fire_md = st[1] == ARMED && st_nx[1] == HOLD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hit_cnt <= '0;
        else if (fire_md && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
    end

    assign bus.hit_cnt = hit_cnt;
`else
    assign bus.hit_cnt = '0;
`endif
endmodule
